pipeline_hazard_ctrl: RTL and testbench

//  Sequences the ID stage of the 5-stage ARM pipeline.
//  - Keeps a scoreboard of in-flight register writes; drives the ID hazard bubble and holds PC and IF/ID.
//  - Flushes IF/ID on a taken branch.
//  - Freezes the whole pipeline while the data memory is busy.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 74 +++++++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
//==============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types and constants for the ID-stage hazard controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    localparam int c_reg_w          = 4;
    localparam int c_pipe_depth_def = 3;

    typedef logic [c_reg_w-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_MWAIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        logic     is_load;
    } sb_entry_t;

    localparam sb_entry_t c_sb_empty = '{valid: 1'b0, dest: '0, is_load: 1'b0};

    function automatic logic sb_hit(input sb_entry_t entry, input reg_idx_t src);
        return entry.valid && (entry.dest == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
//==============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : ID-stage operand/event inputs and pipeline control outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    reg_idx_t         id_rn;
    reg_idx_t         id_rdm;
    logic             id_two_src;
    logic             id_wb_en;
    reg_idx_t         id_dest;
    logic             id_mem_read;
    logic             ex_br_taken;
    logic             mem_busy;
    logic             hazard;
    logic             freeze_if;
    logic             flush;
    logic             freeze_all;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: presents the ID instruction and events, obeys controls.
    modport master (
        output id_rn, id_rdm, id_two_src, id_wb_en, id_dest, id_mem_read,
        output ex_br_taken, mem_busy,
        input  hazard, freeze_if, flush, freeze_all, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_rn, id_rdm, id_two_src, id_wb_en, id_dest, id_mem_read,
        input  ex_br_taken, mem_busy,
        output hazard, freeze_if, flush, freeze_all, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
//==============================================================================
// Module      : pipeline_hazard_ctrl_scoreboard
// Description : Shift register of in-flight register writes plus source match.
//               FORWARDING_EN: only a load in slot 0 can raise raw hazard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_hazard_ctrl_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = c_pipe_depth_def
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t i_id_rn,
    input  reg_idx_t i_id_rdm,
    input  logic     i_id_two_src,
    input  logic     i_id_wb_en,
    input  reg_idx_t i_id_dest,
    input  logic     i_id_mem_read,
    input  logic     i_hold,
    input  logic     i_kill,
    output logic     o_raw_hazard
);

    sb_entry_t r_slot [PIPE_DEPTH];
    sb_entry_t w_new_entry;

    // A bubbled or flushed ID instruction never reaches writeback.
    always_comb begin
        w_new_entry         = c_sb_empty;
        w_new_entry.valid   = i_id_wb_en & ~i_kill;
        w_new_entry.dest    = i_id_dest;
        w_new_entry.is_load = i_id_mem_read;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_slot[i] <= c_sb_empty;
            end
        end else if (!i_hold) begin
            r_slot[0] <= w_new_entry;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

`ifdef FORWARDING_EN
    // ALU results are forwarded; only a load one stage ahead needs a bubble.
    always_comb begin
        o_raw_hazard = 1'b0;
        if (r_slot[0].is_load) begin
            o_raw_hazard = sb_hit(r_slot[0], i_id_rn) ||
                           (i_id_two_src && sb_hit(r_slot[0], i_id_rdm));
        end
    end
`else
    always_comb begin
        o_raw_hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_hit(r_slot[i], i_id_rn) ||
                (i_id_two_src && sb_hit(r_slot[i], i_id_rdm))) begin
                o_raw_hazard = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//==============================================================================
// Module      : pipeline_hazard_ctrl
// Description : ID-stage sequencer: hazard bubbles, branch flush, memory freeze.
//               FORWARDING_EN restricts hazards to load-use.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = c_pipe_depth_def,
    parameter int FLUSH_CYC  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  ctl
);

    localparam logic [1:0] c_flush_load = 2'(FLUSH_CYC - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      r_ret_state;
    logic [1:0]       r_fcnt;
    logic [CNT_W-1:0] r_stall_cnt;

    ctrl_state_t      w_state_nxt;
    ctrl_state_t      w_ret_nxt;
    ctrl_state_t      w_eff_state;
    logic [1:0]       w_fcnt_nxt;
    logic             w_flush;
    logic             w_freeze_all;
    logic             w_raw_hazard;
    logic             w_hazard;

    pipeline_hazard_ctrl_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_id_rn       (ctl.id_rn),
        .i_id_rdm      (ctl.id_rdm),
        .i_id_two_src  (ctl.id_two_src),
        .i_id_wb_en    (ctl.id_wb_en),
        .i_id_dest     (ctl.id_dest),
        .i_id_mem_read (ctl.id_mem_read),
        .i_hold        (w_freeze_all),
        .i_kill        (w_hazard | w_flush),
        .o_raw_hazard  (w_raw_hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_fcnt      <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_fcnt      <= w_fcnt_nxt;
        end
    end

    // MWAIT behaves as the state it interrupted as soon as mem_busy drops, so
    // the freeze lasts exactly as long as mem_busy and a held branch re-presents.
    always_comb begin
        w_eff_state  = (r_state == ST_MWAIT) ? r_ret_state : r_state;
        w_state_nxt  = w_eff_state;
        w_ret_nxt    = r_ret_state;
        w_fcnt_nxt   = r_fcnt;
        w_flush      = 1'b0;
        w_freeze_all = 1'b0;
        if (ctl.mem_busy) begin
            w_freeze_all = 1'b1;
            w_state_nxt  = ST_MWAIT;
            w_ret_nxt    = w_eff_state;
        end else begin
            case (w_eff_state)
                ST_FLUSH: begin
                    w_flush    = 1'b1;
                    w_fcnt_nxt = r_fcnt - 2'd1;
                    if (w_fcnt_nxt == 2'd0) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    // Branch cycle is the first flush cycle; FLUSH covers the rest.
                    if (ctl.ex_br_taken) begin
                        w_flush     = 1'b1;
                        w_fcnt_nxt  = c_flush_load;
                        w_state_nxt = (c_flush_load == 2'd0) ? ST_RUN : ST_FLUSH;
                    end
                end
            endcase
        end
    end

    assign w_hazard = rst & w_raw_hazard & ~w_flush & ~w_freeze_all;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Every output reads zero while reset is held, whatever the inputs do.
    assign ctl.hazard     = w_hazard;
    assign ctl.flush      = rst & w_flush;
    assign ctl.freeze_all = rst & w_freeze_all;
    assign ctl.freeze_if  = w_hazard | (rst & w_freeze_all);
    assign ctl.stall_cnt  = rst ? r_stall_cnt : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//==============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl with a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int PIPE_DEPTH = 3;
    localparam int FLUSH_CYC  = 2;
    localparam int CNT_W      = 4;
    localparam int c_cnt_max  = (1 << CNT_W) - 1;

    typedef struct {
        logic hazard;
        logic freeze_if;
        logic flush;
        logic freeze_all;
        int   cnt;
    } exp_t;

    typedef struct {
        int dest;
        bit is_load;
        int age;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) ctl ();

    pipeline_hazard_ctrl #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .FLUSH_CYC  (FLUSH_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ctl)
    );

    exp_t exp_q[$];
    wr_t  inflight[$];
    int   flush_owed  = 0;
    int   hz_total    = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic bit conflict(input int rn, input int rdm, input bit two);
        foreach (inflight[i]) begin
`ifdef FORWARDING_EN
            if (inflight[i].age == 1 && inflight[i].is_load &&
                (inflight[i].dest == rn || (two && inflight[i].dest == rdm)))
                return 1'b1;
`else
            if (inflight[i].age <= PIPE_DEPTH &&
                (inflight[i].dest == rn || (two && inflight[i].dest == rdm)))
                return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    // One ID cycle: drive inputs, predict outputs, then advance the model.
    task automatic step(input bit rst_n, input int rn, input int rdm, input bit two,
                        input bit wb, input int dest, input bit ld,
                        input bit br, input bit busy);
        exp_t e;
        bit   fl;
        bit   hz;
        wr_t  keep[$];
        wr_t  nw;
        @(posedge clk);
        #1;
        rst              = rst_n;
        ctl.id_rn        = 4'(rn);
        ctl.id_rdm       = 4'(rdm);
        ctl.id_two_src   = two;
        ctl.id_wb_en     = wb;
        ctl.id_dest      = 4'(dest);
        ctl.id_mem_read  = ld;
        ctl.ex_br_taken  = br;
        ctl.mem_busy     = busy;
        e = '{hazard: 1'b0, freeze_if: 1'b0, flush: 1'b0, freeze_all: 1'b0, cnt: 0};
        if (!rst_n) begin
            exp_q.push_back(e);
            inflight.delete();
            flush_owed = 0;
            hz_total   = 0;
        end else if (busy) begin
            e.freeze_all = 1'b1;
            e.freeze_if  = 1'b1;
            e.cnt        = (hz_total > c_cnt_max) ? c_cnt_max : hz_total;
            exp_q.push_back(e);
        end else begin
            fl = 1'b0;
            hz = 1'b0;
            if (flush_owed > 0) begin
                fl = 1'b1;
                flush_owed--;
            end else if (br) begin
                fl = 1'b1;
                flush_owed = FLUSH_CYC - 1;
            end else begin
                hz = conflict(rn, rdm, two);
            end
            e.flush     = fl;
            e.hazard    = hz;
            e.freeze_if = hz;
            e.cnt       = (hz_total > c_cnt_max) ? c_cnt_max : hz_total;
            exp_q.push_back(e);
            if (hz) hz_total++;
            foreach (inflight[i]) begin
                if (inflight[i].age + 1 <= PIPE_DEPTH) begin
                    nw     = inflight[i];
                    nw.age = nw.age + 1;
                    keep.push_back(nw);
                end
            end
            if (wb && !hz && !fl) begin
                nw = '{dest: dest, is_load: ld, age: 1};
                keep.push_back(nw);
            end
            inflight = keep;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT mid-cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (ctl.hazard !== e.hazard || ctl.freeze_if !== e.freeze_if ||
                    ctl.flush !== e.flush || ctl.freeze_all !== e.freeze_all ||
                    ctl.stall_cnt !== CNT_W'(e.cnt)) begin
                    miscompares++;
                    $display("FAIL ctrl vec %0d: hz/fif/fl/fa/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                             vectors, ctl.hazard, ctl.freeze_if, ctl.flush, ctl.freeze_all,
                             ctl.stall_cnt, e.hazard, e.freeze_if, e.flush, e.freeze_all, e.cnt);
                end
            end
        end
    end

    initial begin
        int busy_left;
        bit r_n;
        ctl.id_rn = '0; ctl.id_rdm = '0; ctl.id_two_src = 1'b0; ctl.id_wb_en = 1'b0;
        ctl.id_dest = '0; ctl.id_mem_read = 1'b0; ctl.ex_br_taken = 1'b0; ctl.mem_busy = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // ADD R1 then SUB R2,R1,R3 held in ID until the bubble clears.
        step(1, 5, 6, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 1, 1, 2, 0, 0, 0);
        idle(2);

        // LDR R1 then ADD R2,R1,R1.
        step(1, 5, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 1, 2, 0, 0, 0);
        idle(4);

        // Taken branch pulse with an instruction in ID.
        step(1, 0, 0, 0, 1, 7, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 0, 0, 0, 0, 0);

        // mem_busy for 4 cycles while a hazard is pending.
        step(1, 0, 0, 0, 1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 4, 0, 0, 1, 5, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4, 0, 0, 1, 5, 0, 0, 0);
        idle(3);

        // Branch together with mem_busy; branch re-presents after the freeze.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // Reset while frozen with valid entries.
        step(1, 0, 0, 0, 1, 6, 0, 0, 0);
        step(1, 0, 0, 0, 1, 7, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 6, 7, 1, 0, 0, 0, 0, 1);
        step(1, 6, 7, 1, 0, 0, 0, 0, 0);
        step(1, 7, 6, 1, 0, 0, 0, 0, 0);

        busy_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (busy_left > 0) busy_left--;
            else if ($urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 5);
            r_n = ($urandom_range(0, 149) != 0);
            step(r_n, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 3), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 11) == 0), (busy_left > 0));
        end
        idle(2);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
